// File: rtl/line_roi_sampler.sv
// line_roi_sampler: line-scan peak detector with one programmable window per
// channel. Once per complete line it reports the window peak of each channel
// and a light/dark sample bit derived from per-channel thresholds.
// Window/threshold writes go to a shadow copy that becomes active only at line
// boundaries (line completion, line abort, or while enable is low).
// Optional build macro: ROI_HYSTERESIS_EN adds a per-channel low threshold and
// makes the sample bit a set/clear hysteresis decision instead of a plain
// compare against the high threshold.
module line_roi_sampler #(
  parameter int CHANNELS          = 3,
  parameter int PIXEL_WIDTH       = 8,
  parameter int INDEX_WIDTH       = 11,
  parameter int DARK_PIXELS       = 16,
  parameter int LINE_PIXELS       = 1024,
  parameter int DEFAULT_STRIDE    = 256,
  parameter int DEFAULT_WIDTH     = 32,
  parameter int DEFAULT_THRESHOLD = 96
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            line_start,
  input  logic                            pixel_valid,
  input  logic [PIXEL_WIDTH-1:0]          pixel_data,
  input  logic                            cfg_write,
  input  logic [3:0]                      cfg_channel,
  input  logic [1:0]                      cfg_field,
  input  logic [INDEX_WIDTH-1:0]          cfg_value,
  output logic [CHANNELS-1:0]             sample,
  output logic                            sample_valid,
  output logic [CHANNELS*PIXEL_WIDTH-1:0] peak,
  output logic                            short_line,
  output logic [CHANNELS-1:0]             cfg_error,
  output logic [15:0]                     line_count
);

  localparam int LINE_LEN = DARK_PIXELS + LINE_PIXELS;
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(LINE_LEN - 1);
  localparam logic [PIXEL_WIDTH-1:0] DEF_THR  = PIXEL_WIDTH'(DEFAULT_THRESHOLD);

  function automatic logic [PIXEL_WIDTH-1:0] pix_max(input logic [PIXEL_WIDTH-1:0] a,
                                                     input logic [PIXEL_WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [INDEX_WIDTH-1:0] default_start(input int k);
    return INDEX_WIDTH'(DARK_PIXELS + 2 + k * DEFAULT_STRIDE);
  endfunction

  function automatic logic [INDEX_WIDTH-1:0] default_stop(input int k);
    return INDEX_WIDTH'(DARK_PIXELS + 2 + k * DEFAULT_STRIDE + DEFAULT_WIDTH);
  endfunction

`ifdef ROI_HYSTERESIS_EN
  // Set above high, clear below low, otherwise keep the previous decision.
  function automatic logic hyst_decide(input logic [PIXEL_WIDTH-1:0] pk,
                                       input logic [PIXEL_WIDTH-1:0] hi,
                                       input logic [PIXEL_WIDTH-1:0] lo,
                                       input logic                   prev);
    if (pk > hi) return 1'b1;
    if (pk < lo) return 1'b0;
    return prev;
  endfunction
`endif

  // ---- stage p0: pixel acceptance, effective index and line events ----
  logic [INDEX_WIDTH-1:0] idx;
  logic                   accept_p0;
  logic [INDEX_WIDTH-1:0] eff_idx_p0;
  logic                   abort_p0;
  logic                   done_p0;
  logic                   copy_p0;

  assign accept_p0  = enable & pixel_valid;
  // A line_start pixel is always index 0, whatever the counter says.
  assign eff_idx_p0 = line_start ? '0 : idx;
  assign abort_p0   = accept_p0 & line_start & (idx != '0);
  assign done_p0    = accept_p0 & (eff_idx_p0 == LAST_IDX);
  // Shadow config becomes active only where no line is being accumulated.
  assign copy_p0    = done_p0 | abort_p0 | ~enable;

  // Pixel index counter; stalls on gaps, restarts at line end or line_start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (!enable) begin
      idx <= '0;
    end else if (accept_p0) begin
      idx <= done_p0 ? '0 : eff_idx_p0 + 1'b1;
    end
  end

  // ---- stage p1: per-line event pulses and completed-line counter ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample_valid <= 1'b0;
      short_line   <= 1'b0;
      line_count   <= '0;
    end else begin
      sample_valid <= done_p0;
      short_line   <= abort_p0;
      if (done_p0) line_count <= line_count + 16'd1;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [INDEX_WIDTH-1:0] sh_start, sh_stop, act_start, act_stop;
    logic [PIXEL_WIDTH-1:0] sh_high, act_high;
`ifdef ROI_HYSTERESIS_EN
    logic [PIXEL_WIDTH-1:0] sh_low, act_low;
`endif
    logic [PIXEL_WIDTH-1:0] run_max, peak_q, base_p0, fold_p0;
    logic                   sample_q, win_ok, in_win_p0, sel_p0, next_sample_p0;

    // Channel numbers without a generate instance never match, so
    // out-of-range writes fall through silently.
    assign sel_p0    = cfg_write && ({1'b0, cfg_channel} == 5'(k));
    assign win_ok    = act_start < act_stop;
    assign in_win_p0 = win_ok && (eff_idx_p0 >= act_start) && (eff_idx_p0 < act_stop);
    // An aborted line contributes nothing to the new line's maximum.
    assign base_p0   = abort_p0 ? '0 : run_max;
    assign fold_p0   = in_win_p0 ? pix_max(base_p0, pixel_data) : base_p0;

`ifdef ROI_HYSTERESIS_EN
    assign next_sample_p0 = win_ok ? hyst_decide(fold_p0, act_high, act_low, sample_q) : 1'b0;
`else
    assign next_sample_p0 = win_ok && (fold_p0 > act_high);
`endif

    // Shadow configuration: written by the register port at any time.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sh_start <= default_start(k);
        sh_stop  <= default_stop(k);
        sh_high  <= DEF_THR;
`ifdef ROI_HYSTERESIS_EN
        sh_low   <= DEF_THR;
`endif
      end else if (sel_p0) begin
        case (cfg_field)
          2'd0: sh_start <= cfg_value;
          2'd1: sh_stop  <= cfg_value;
          2'd2: sh_high  <= cfg_value[PIXEL_WIDTH-1:0];
`ifdef ROI_HYSTERESIS_EN
          2'd3: sh_low   <= cfg_value[PIXEL_WIDTH-1:0];
`endif
          default: ;
        endcase
      end
    end

    // Active configuration: refreshed from shadow at line boundaries only.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        act_start <= default_start(k);
        act_stop  <= default_stop(k);
        act_high  <= DEF_THR;
`ifdef ROI_HYSTERESIS_EN
        act_low   <= DEF_THR;
`endif
      end else if (copy_p0) begin
        act_start <= sh_start;
        act_stop  <= sh_stop;
        act_high  <= sh_high;
`ifdef ROI_HYSTERESIS_EN
        act_low   <= sh_low;
`endif
      end
    end

    // Running window maximum; published as peak/sample on the last pixel.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        run_max  <= '0;
        peak_q   <= '0;
        sample_q <= 1'b0;
      end else if (!enable) begin
        run_max  <= '0;
      end else if (accept_p0) begin
        if (done_p0) begin
          run_max  <= '0;
          peak_q   <= win_ok ? fold_p0 : '0;
          sample_q <= next_sample_p0;
        end else begin
          run_max  <= fold_p0;
        end
      end
    end

    assign peak[k*PIXEL_WIDTH +: PIXEL_WIDTH] = peak_q;
    assign sample[k]                          = sample_q;
    assign cfg_error[k]                       = ~win_ok;
  end

endmodule

// File: tb/tb_line_roi_sampler.sv
// Directed bench for line_roi_sampler: drives whole lines from a pixel array,
// predicts each line's result from the window/threshold rules and checks every
// sample_valid and short_line pulse, plus literal spot checks.
module tb_line_roi_sampler;
  localparam int CH = 3;
  localparam int PW = 8;
  localparam int IW = 11;
  localparam int L  = 1040;

  logic              clock = 1'b0;
  logic              reset, enable, line_start, pixel_valid, cfg_write;
  logic [PW-1:0]     pixel_data;
  logic [3:0]        cfg_channel;
  logic [1:0]        cfg_field;
  logic [IW-1:0]     cfg_value;
  logic [CH-1:0]     sample, cfg_error;
  logic              sample_valid, short_line;
  logic [CH*PW-1:0]  peak;
  logic [15:0]       line_count;

  line_roi_sampler dut (
    .clock(clock), .reset(reset), .enable(enable), .line_start(line_start),
    .pixel_valid(pixel_valid), .pixel_data(pixel_data), .cfg_write(cfg_write),
    .cfg_channel(cfg_channel), .cfg_field(cfg_field), .cfg_value(cfg_value),
    .sample(sample), .sample_valid(sample_valid), .peak(peak),
    .short_line(short_line), .cfg_error(cfg_error), .line_count(line_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  typedef struct {
    int               cyc;
    logic [CH-1:0]    s;
    logic [CH*PW-1:0] p;
    logic [15:0]      lc;
  } exp_t;

  typedef struct {
    int at; int ch; int f; int v;
  } wr_t;

  exp_t exp_q[$];
  int   short_q[$];
  wr_t  mid_wr[$];

  // Model state: shadow and active config, previous samples, line counter.
  int   sh_start[CH], sh_stop[CH], sh_hi[CH], sh_lo[CH];
  int   ac_start[CH], ac_stop[CH], ac_hi[CH], ac_lo[CH];
  logic m_samp[CH];
  int   m_lc = 0;
  bit   partial_pending = 0;
  logic [PW-1:0] px[L];

  function automatic void model_reset();
    for (int k = 0; k < CH; k++) begin
      sh_start[k] = 18 + k * 256; sh_stop[k] = sh_start[k] + 32;
      sh_hi[k] = 96; sh_lo[k] = 96;
      m_samp[k] = 1'b0;
    end
    ac_start = sh_start; ac_stop = sh_stop; ac_hi = sh_hi; ac_lo = sh_lo;
    m_lc = 0;
  endfunction

  function automatic void model_copy();
    ac_start = sh_start; ac_stop = sh_stop; ac_hi = sh_hi; ac_lo = sh_lo;
  endfunction

  function automatic void model_write(input int ch, input int f, input int v);
    if (ch < CH) begin
      case (f)
        0: sh_start[ch] = v;
        1: sh_stop[ch]  = v;
        2: sh_hi[ch]    = v % 256;
`ifdef ROI_HYSTERESIS_EN
        3: sh_lo[ch]    = v % 256;
`endif
        default: ;
      endcase
    end
  endfunction

  // Result of a complete line under the currently active config.
  function automatic exp_t model_line();
    exp_t e;
    e.s = '0; e.p = '0;
    for (int k = 0; k < CH; k++) begin
      int mx = 0;
      logic s;
      if (ac_start[k] < ac_stop[k]) begin
        for (int i = ac_start[k]; i < ac_stop[k] && i < L; i++)
          if (int'(px[i]) > mx) mx = int'(px[i]);
`ifdef ROI_HYSTERESIS_EN
        if (mx > ac_hi[k]) s = 1'b1;
        else if (mx < ac_lo[k]) s = 1'b0;
        else s = m_samp[k];
`else
        s = (mx > ac_hi[k]);
`endif
      end else begin
        s = 1'b0;
      end
      m_samp[k] = s;
      e.s[k] = s;
      e.p[k*PW +: PW] = PW'(mx);
    end
    m_lc = (m_lc + 1) % 65536;
    e.lc = 16'(m_lc);
    return e;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_px();
    for (int i = 0; i < L; i++) px[i] = '0;
  endtask

  task automatic cfg_wr(input int ch, input int f, input int v);
    cfg_write = 1'b1; cfg_channel = 4'(ch); cfg_field = 2'(f); cfg_value = IW'(v);
    step();
    cfg_write = 1'b0;
    model_write(ch, f, v);
  endtask

  // Full line from px[]; gap inserts an idle cycle before every pixel.
  task automatic run_line(input bit gap);
    exp_t e;
    if (partial_pending) model_copy();
    e = model_line();
    for (int i = 0; i < L; i++) begin
      if (gap) begin
        pixel_valid = 1'b0; line_start = 1'b0; cfg_write = 1'b0;
        step();
      end
      pixel_valid = 1'b1; line_start = (i == 0); pixel_data = px[i]; cfg_write = 1'b0;
      if (mid_wr.size() > 0 && mid_wr[0].at == i) begin
        wr_t w = mid_wr.pop_front();
        cfg_write = 1'b1; cfg_channel = 4'(w.ch); cfg_field = 2'(w.f); cfg_value = IW'(w.v);
        model_write(w.ch, w.f, w.v);
      end
      if (i == 0 && partial_pending) short_q.push_back(cyc + 1);
      if (i == L - 1) begin
        e.cyc = cyc + 1;
        exp_q.push_back(e);
      end
      step();
    end
    pixel_valid = 1'b0; line_start = 1'b0; cfg_write = 1'b0;
    partial_pending = 0;
    model_copy();
  endtask

  task automatic partial_line(input int n, input logic [PW-1:0] v);
    for (int i = 0; i < n; i++) begin
      pixel_valid = 1'b1; line_start = (i == 0); pixel_data = v;
      step();
    end
    pixel_valid = 1'b0; line_start = 1'b0;
    partial_pending = 1;
  endtask

  task automatic enable_low(input int n);
    enable = 1'b0;
    for (int i = 0; i < n; i++) step();
    enable = 1'b1;
    model_copy();
    partial_pending = 0;
  endtask

  // Compare process: every output event is matched against the model.
  exp_t got;
  always @(negedge clock) begin
    if (!reset) begin
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sample_valid", 64'(sample_valid), 64'd0);
        end else begin
          got = exp_q.pop_front();
          check("sv_cycle", 64'(cyc), 64'(got.cyc));
          check("sample", 64'(sample), 64'(got.s));
          check("peak", 64'(peak), 64'(got.p));
          check("line_count", 64'(line_count), 64'(got.lc));
        end
      end
      if (short_line) begin
        if (short_q.size() == 0) check("unexpected_short_line", 64'(short_line), 64'd0);
        else check("short_cycle", 64'(cyc), 64'(short_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b1; line_start = 1'b0; pixel_valid = 1'b0;
    pixel_data = '0; cfg_write = 1'b0; cfg_channel = '0; cfg_field = '0; cfg_value = '0;
    model_reset();
    step(); step();
    check("rst_sample", 64'(sample), 64'd0);
    check("rst_sample_valid", 64'(sample_valid), 64'd0);
    check("rst_peak", 64'(peak), 64'd0);
    check("rst_short_line", 64'(short_line), 64'd0);
    check("rst_cfg_error", 64'(cfg_error), 64'd0);
    check("rst_line_count", 64'(line_count), 64'd0);
    reset = 1'b0;
    step();

    // Line A then B back to back.
    clear_px(); px[20] = 8'd200;
    run_line(1'b0);
    check("A_sample", 64'(sample), 64'b001);
    check("A_peak0", 64'(peak[7:0]), 64'd200);
    check("A_count", 64'(line_count), 64'd1);
    clear_px(); px[50] = 8'd150; px[49] = 8'd90;
    run_line(1'b0);
    check("B_peak0", 64'(peak[7:0]), 64'd90);
    check("B_sample0", 64'(sample[0]), 64'd0);

    // Abort at idx 500, then a normal line.
    partial_line(500, 8'd250);
    check("abort_count_held", 64'(line_count), 64'd2);
    clear_px(); px[280] = 8'd120;
    run_line(1'b0);
    check("C_peak1", 64'(peak[15:8]), 64'd120);

    // Mid-line window move on ch1 takes effect on the following line.
    clear_px(); px[280] = 8'd130; px[605] = 8'd90;
    mid_wr.push_back('{at: 100, ch: 1, f: 0, v: 600});
    mid_wr.push_back('{at: 101, ch: 1, f: 1, v: 610});
    run_line(1'b0);
    check("D_peak1_old_window", 64'(peak[15:8]), 64'd130);
    run_line(1'b0);
    check("E_peak1_new_window", 64'(peak[15:8]), 64'd90);

    // Degenerate window start == stop.
    step();
    cfg_wr(1, 0, 600); cfg_wr(1, 1, 600);
    clear_px(); px[605] = 8'd200;
    run_line(1'b0);
    check("F_peak1", 64'(peak[15:8]), 64'd200);
    check("F_cfg_error", 64'(cfg_error), 64'b010);
    run_line(1'b0);
    check("G_sample1", 64'(sample[1]), 64'd0);
    check("G_peak1", 64'(peak[15:8]), 64'd0);

    // Gapped stream versus continuous stream with identical pixels.
    clear_px(); px[20] = 8'd97; px[49] = 8'd10; px[540] = 8'd99;
    run_line(1'b1);
    check("H_sample", 64'(sample), 64'b101);
    run_line(1'b0);
    check("I_sample", 64'(sample), 64'b101);

    // Enable drop mid-line discards it without short_line.
    cfg_wr(0, 2, 150);
    partial_line(300, 8'd250);
    enable_low(3);
    clear_px(); px[20] = 8'd120;
    run_line(1'b0);
    check("J_peak0", 64'(peak[7:0]), 64'd120);

    // Ignored writes, then strict '>' at the threshold.
    cfg_wr(5, 0, 0);
    cfg_wr(0, 3, 0);
    clear_px(); px[20] = 8'd150;
    run_line(1'b0);
    check("K_peak0", 64'(peak[7:0]), 64'd150);

`ifdef ROI_HYSTERESIS_EN
    cfg_wr(0, 2, 100); cfg_wr(0, 3, 50);
    clear_px();
    run_line(1'b0);
    px[20] = 8'd120; run_line(1'b0);
    check("hyst_120", 64'(sample[0]), 64'd1);
    px[20] = 8'd80;  run_line(1'b0);
    check("hyst_80", 64'(sample[0]), 64'd1);
    px[20] = 8'd40;  run_line(1'b0);
    check("hyst_40", 64'(sample[0]), 64'd0);
`else
    check("K_sample0", 64'(sample[0]), 64'd0);
`endif

    for (int i = 0; i < 5; i++) step();
    check("pending_sample_valid", 64'(exp_q.size()), 64'd0);
    check("pending_short_line", 64'(short_q.size()), 64'd0);
    check("final_line_count", 64'(line_count), 64'(m_lc));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
